// File: rtl/gsim_pkg.sv
// Shared constants and types for the Gauss-Seidel matrix loader and core.
// One matrix is 17 consecutive 256-bit words: vector b followed by rows 0..15 of A.
package gsim_pkg;

   localparam int MTX_WORDS = 17;
   localparam int WORD_W    = 256;
   localparam int ADDR_W    = 10;
   localparam int ELEM_W    = 16;
   localparam int ROW_ELEMS = WORD_W / ELEM_W;
   localparam int TAG_W     = 5;
   localparam int IDX_W     = 5;
   localparam int ROW_W     = TAG_W + WORD_W;

   localparam logic [TAG_W-1:0] LAST_WORD = TAG_W'(MTX_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DRAIN,
      DONE
   } loader_state_t;

   // Word address of the first word (vector b) of matrix idx; 31*17+16 fits in 10 bits.
   function automatic logic [ADDR_W-1:0] mtx_base(input logic [IDX_W-1:0] idx);
      return ADDR_W'(idx) * ADDR_W'(MTX_WORDS);
   endfunction

endpackage

// File: rtl/gsim_row_fifo.sv
// Synchronous first-word-fall-through FIFO: a storage array with registered read
// feeding a head register, so rd_data/empty come straight from flops.
module gsim_row_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] head_reg;
   logic             head_vld_reg, head_vld_next;
   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0] mem_cnt_reg, mem_cnt_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             pop, push, head_load, from_mem, bypass, mem_wr;

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = !head_vld_reg;
   assign count   = count_reg;
   assign rd_data = head_reg;

   // The head refills whenever it is empty or being popped; the array only holds
   // words behind the head, so an empty array lets a write bypass straight to the head.
   always_comb begin
      pop           = head_vld_reg && rd_en;
      push          = wr_en && (!full || pop);
      head_load     = !head_vld_reg || pop;
      from_mem      = head_load && (mem_cnt_reg != '0);
      bypass        = head_load && (mem_cnt_reg == '0) && push;
      mem_wr        = push && !bypass;
      head_vld_next = head_vld_reg;
      if (head_load) begin
         head_vld_next = from_mem || bypass;
      end
      wr_ptr_next  = wr_ptr_reg + PTR_W'(mem_wr);
      rd_ptr_next  = rd_ptr_reg + PTR_W'(from_mem);
      mem_cnt_next = mem_cnt_reg + CNT_W'(mem_wr) - CNT_W'(from_mem);
      count_next   = count_reg + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge i_clk) begin
      if (mem_wr) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         head_reg     <= '0;
         head_vld_reg <= 1'b0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         mem_cnt_reg  <= '0;
         count_reg    <= '0;
      end else begin
         if (from_mem) begin
            head_reg <= mem[rd_ptr_reg];
         end else if (bypass) begin
            head_reg <= wr_data;
         end
         head_vld_reg <= head_vld_next;
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         mem_cnt_reg  <= mem_cnt_next;
         count_reg    <= count_next;
      end
   end

endmodule

// File: rtl/gsim_mtx_loader.sv
// Fetches the 17 words of one matrix from matrix memory and hands them to the
// Gauss-Seidel core as tagged rows (0 = b, 1..16 = A rows) through a row FIFO.
module gsim_mtx_loader
   import gsim_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic [IDX_W-1:0]    i_mtx_idx,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_mem_rreq,
   output logic [ADDR_W-1:0]   o_mem_addr,
   input  logic                i_mem_rrdy,
   input  logic [WORD_W-1:0]   i_mem_dout,
   input  logic                i_mem_dout_vld,
   output logic                o_row_vld,
   output logic [TAG_W-1:0]    o_row_idx,
   output logic [WORD_W-1:0]   o_row_data,
   input  logic                i_row_rdy
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W:0] CREDIT_MAX = FIFO_DEPTH[CNT_W:0];

   loader_state_t     state_reg, state_next;
   logic [ADDR_W-1:0] base_reg, base_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [TAG_W-1:0]  k_reg, k_next;
   logic [TAG_W-1:0]  tag_reg, tag_next;
   logic [TAG_W-1:0]  pop_cnt_reg, pop_cnt_next;
   logic [CNT_W-1:0]  inflight_reg, inflight_next;
   logic [CNT_W-1:0]  fifo_count_next;
   logic [CNT_W:0]    credit_used;
   logic              rreq_reg, rreq_next;
   logic              busy_reg, busy_next;
   logic              done_reg, done_next;

   logic [ROW_W-1:0]  fifo_rd_data;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full, fifo_empty;
   logic              issue, resp_acc, row_pop, start_acc;

   always_comb begin
      row_pop   = !fifo_empty && i_row_rdy;
      issue     = rreq_reg && i_mem_rrdy;
      // Responses with nothing in flight are strays (or from before a reset).
      resp_acc  = i_mem_dout_vld && (inflight_reg != '0) && (!fifo_full || row_pop);
      start_acc = (state_reg == IDLE) && i_start;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_reg    <= IDLE;
         base_reg     <= '0;
         addr_reg     <= '0;
         k_reg        <= '0;
         tag_reg      <= '0;
         pop_cnt_reg  <= '0;
         inflight_reg <= '0;
         rreq_reg     <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         base_reg     <= base_next;
         addr_reg     <= addr_next;
         k_reg        <= k_next;
         tag_reg      <= tag_next;
         pop_cnt_reg  <= pop_cnt_next;
         inflight_reg <= inflight_next;
         rreq_reg     <= rreq_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (i_start) state_next = REQ;
         REQ:     if (issue && (k_reg == LAST_WORD)) state_next = DRAIN;
         DRAIN:   if (row_pop && (pop_cnt_reg == LAST_WORD)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      base_next    = base_reg;
      k_next       = k_reg;
      tag_next     = tag_reg;
      pop_cnt_next = pop_cnt_reg;
      if (start_acc) begin
         base_next    = mtx_base(i_mtx_idx);
         k_next       = '0;
         tag_next     = '0;
         pop_cnt_next = '0;
      end else begin
         if (issue)    k_next       = k_reg + TAG_W'(1);
         if (resp_acc) tag_next     = tag_reg + TAG_W'(1);
         if (row_pop)  pop_cnt_next = pop_cnt_reg + TAG_W'(1);
      end
      inflight_next   = inflight_reg + CNT_W'(issue) - CNT_W'(resp_acc);
      fifo_count_next = fifo_count + CNT_W'(resp_acc) - CNT_W'(row_pop);
   end

   // Outputs are registered from next-state values. A request is only raised when
   // every word already requested but not yet popped still leaves a FIFO slot free;
   // since only an acceptance uses up credit, a pending request never drops early.
   always_comb begin
      busy_next   = (state_next == REQ) || (state_next == DRAIN);
      done_next   = (state_next == DONE);
      credit_used = {1'b0, inflight_next} + {1'b0, fifo_count_next};
      rreq_next   = (state_next == REQ) && (credit_used < CREDIT_MAX);
      addr_next   = addr_reg;
      if (state_next == REQ) begin
         addr_next = base_next + ADDR_W'(k_next);
      end
   end

   gsim_row_fifo #(
      .WIDTH (ROW_W),
      .DEPTH (FIFO_DEPTH)
   ) u_row_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .wr_en   (resp_acc),
      .wr_data ({tag_reg, i_mem_dout}),
      .rd_en   (i_row_rdy),
      .rd_data (fifo_rd_data),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign o_busy     = busy_reg;
   assign o_done     = done_reg;
   assign o_mem_rreq = rreq_reg;
   assign o_mem_addr = addr_reg;
   assign o_row_vld  = !fifo_empty;
   assign o_row_idx  = fifo_rd_data[ROW_W-1 -: TAG_W];

   for (genvar gi = 0; gi < ROW_ELEMS; gi++) begin : g_elem
      assign o_row_data[gi*ELEM_W +: ELEM_W] = fifo_rd_data[gi*ELEM_W +: ELEM_W];
   end

endmodule

// File: tb/tb_gsim_mtx_loader.sv
// Randomized directed bench for gsim_mtx_loader: in-order memory model with
// variable latency and an event-count reference of the expected handshakes.
module tb_gsim_mtx_loader;

   localparam int DEPTH = 4;

   logic         i_clk = 1'b0;
   logic         i_reset = 1'b1;
   logic         i_start = 1'b0;
   logic [4:0]   i_mtx_idx = '0;
   logic         o_busy, o_done, o_mem_rreq;
   logic [9:0]   o_mem_addr;
   logic         i_mem_rrdy = 1'b0;
   logic [255:0] i_mem_dout = '0;
   logic         i_mem_dout_vld = 1'b0;
   logic         o_row_vld;
   logic [4:0]   o_row_idx;
   logic [255:0] o_row_data;
   logic         i_row_rdy = 1'b0;

   always #5 i_clk = ~i_clk;

   gsim_mtx_loader #(.FIFO_DEPTH(DEPTH)) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_start        (i_start),
      .i_mtx_idx      (i_mtx_idx),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_mem_rreq     (o_mem_rreq),
      .o_mem_addr     (o_mem_addr),
      .i_mem_rrdy     (i_mem_rrdy),
      .i_mem_dout     (i_mem_dout),
      .i_mem_dout_vld (i_mem_dout_vld),
      .o_row_vld      (o_row_vld),
      .o_row_idx      (o_row_idx),
      .o_row_data     (o_row_data),
      .i_row_rdy      (i_row_rdy)
   );

   int n_cmp = 0, n_err = 0, cyc = 0;
   logic [255:0] mem [0:543];
   int pend_addr[$];
   int pend_due[$];
   int last_due = 0, lat_lo = 1, lat_hi = 1;
   // Reference: a load is a count of requests issued, responses returned and rows popped.
   bit load_active = 0;
   int base_m = 0, issued = 0, popped = 0, rx = 0, stale = 0;
   int exp_done_cyc = -10, done_cnt = 0;

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [260:0] obs, input logic [260:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_done"}, o_done, 0);
      chk({tag, "_rreq"}, o_mem_rreq, 0);
      chk({tag, "_addr"}, o_mem_addr, 0);
      chk({tag, "_row_vld"}, o_row_vld, 0);
      chk({tag, "_row_idx"}, o_row_idx, 0);
      chk({tag, "_row_data"}, o_row_data, 0);
   endtask

   // One clock cycle: drive inputs, check outputs against the reference, update it.
   task automatic tick(input bit start, input logic [4:0] idx, input bit rrdy, input bit rdy,
                       input bit stray);
      bit acc_start, resp;
      int ad, due;
      acc_start = start && !load_active && (cyc != exp_done_cyc);
      i_start = start; i_mtx_idx = idx; i_mem_rrdy = rrdy; i_row_rdy = rdy;
      resp = 0;
      i_mem_dout_vld = 1'b0;
      i_mem_dout = rand256();
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
         ad = pend_addr.pop_front();
         void'(pend_due.pop_front());
         i_mem_dout_vld = 1'b1;
         i_mem_dout = mem[ad];
         resp = 1;
      end else if (stray) begin
         i_mem_dout_vld = 1'b1;
      end
      chk("busy", o_busy, load_active);
      chk("done", o_done, cyc == exp_done_cyc);
      chk("rreq", o_mem_rreq, load_active && issued < 17 && (issued - popped) < DEPTH);
      if (o_mem_rreq) chk("addr", o_mem_addr, base_m + issued);
      chk("row_vld", o_row_vld, rx > popped);
      if (o_row_vld && popped < 17) begin
         chk("row_idx", o_row_idx, popped);
         chk("row_data", o_row_data, mem[base_m + popped]);
      end
      if (o_mem_rreq && rrdy) begin
         due = cyc + $urandom_range(lat_hi, lat_lo);
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         pend_addr.push_back(int'(o_mem_addr));
         pend_due.push_back(due);
         issued++;
      end
      if (resp) begin
         if (stale > 0) stale--;
         else rx++;
      end
      if (o_row_vld && rdy) begin
         $display("row cyc=%0d idx=%0d addr=%0d", cyc, o_row_idx, base_m + popped);
         popped++;
         if (popped == 17) begin
            load_active = 0;
            exp_done_cyc = cyc + 1;
         end
      end
      if (o_done) done_cnt++;
      if (acc_start) begin
         load_active = 1;
         base_m = int'(idx) * 17;
         issued = 0; popped = 0; rx = 0;
      end
      @(posedge i_clk);
      #1;
      cyc++;
   endtask

   // rrdy_mode: 0 always ready, 1 pattern 1,0,0, 2 random. rdy_mode: 0 always, 1 low for 20 cycles, 2 random.
   task automatic run_load(input logic [4:0] idx, input int rrdy_mode, input int rdy_mode,
                           input int lo, input int hi, input bit poke_start, input int exp_lat);
      int s, d0;
      bit fin, rr, rd, st;
      lat_lo = lo; lat_hi = hi;
      s = cyc; d0 = done_cnt; fin = 0;
      tick(1, idx, 1, 1, 0);
      for (int t = 1; t < 800 && !fin; t++) begin
         rr = (rrdy_mode == 0) ? 1'b1 : (rrdy_mode == 1) ? (t % 3 == 1) : 1'($urandom_range(1, 0));
         rd = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (t > 20) : 1'($urandom_range(1, 0));
         st = poke_start && (t == 5 || t == 30);
         if (rdy_mode == 1 && t == 21) chk("bp_issued", issued, DEPTH);
         tick(st, st ? ~idx : idx, rr, rd, 0);
         if (done_cnt != d0) begin
            fin = 1;
            if (exp_lat > 0) chk("done_latency", (cyc - 1) - s, exp_lat);
         end
      end
      chk("load_done", fin, 1);
      tick(0, idx, 1, 1, 0);
      tick(0, idx, 1, 1, 0);
      chk("done_once", done_cnt - d0, 1);
      $display("load idx=%0d start_cyc=%0d end_cyc=%0d", idx, s, cyc);
   endtask

   initial begin
      int guard;
      for (int a = 0; a < 544; a++) mem[a] = rand256();
      repeat (3) @(posedge i_clk);
      #1;
      chk_outputs_zero("reset");
      i_reset = 1'b0;
      tick(0, 0, 1, 1, 0);
      tick(0, 0, 1, 1, 0);

      run_load(5'd2, 0, 0, 1, 1, 0, 20);
      run_load(5'd7, 0, 1, 1, 1, 0, 0);
      run_load(5'd13, 1, 2, 1, 5, 0, 0);
      run_load(5'd31, 2, 2, 1, 3, 1, 0);

      tick(0, 0, 1, 1, 1);
      repeat (3) tick(0, 0, 1, 1, 0);

      lat_lo = 4; lat_hi = 4;
      tick(1, 5'd9, 1, 1, 0);
      guard = 0;
      while (!(issued >= 8 && popped >= 3) && guard < 300) begin
         tick(0, 5'd9, 1, 1'($urandom_range(1, 0)), 0);
         guard++;
      end
      chk("midload_reached", issued >= 8 && popped >= 3, 1);
      chk("late_pending", pend_addr.size() > 0, 1);
      i_reset = 1'b1;
      #1;
      chk_outputs_zero("midreset");
      stale = pend_addr.size();
      load_active = 0; issued = 0; popped = 0; rx = 0; exp_done_cyc = -10;
      i_start = 1'b0; i_mem_dout_vld = 1'b0;
      repeat (2) begin
         @(posedge i_clk);
         #1;
         cyc++;
      end
      i_reset = 1'b0;
      guard = 0;
      while (pend_addr.size() > 0 && guard < 40) begin
         tick(0, 0, 1, 1, 0);
         guard++;
      end
      chk("late_drained", pend_addr.size(), 0);
      tick(0, 0, 1, 1, 0);
      run_load(5'd0, 0, 0, 1, 2, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
